// File: rtl/lc3_decode_stage_if.sv
// Bus between fetch/instruction memory, the LC-3 decode stage and its downstream consumers.
// The decode stage sits on the slave side; the fetch/consumer side uses the master modport.
interface lc3_decode_stage_if #(
    parameter int WIDTH = 16
);
    logic             enable_decode;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] npc_in;
    logic [WIDTH-1:0] instr_dout;
    logic [WIDTH-1:0] npc_out;
    logic [5:0]       E_control_i;
    logic [1:0]       W_control_i;
    logic             Mem_control_i;

    modport master (
        output enable_decode,
        output dout,
        output npc_in,
        input  instr_dout,
        input  npc_out,
        input  E_control_i,
        input  W_control_i,
        input  Mem_control_i
    );

    modport slave (
        input  enable_decode,
        input  dout,
        input  npc_in,
        output instr_dout,
        output npc_out,
        output E_control_i,
        output W_control_i,
        output Mem_control_i
    );
endinterface

// File: rtl/lc3_decode_stage.sv
// LC-3 decode pipeline stage: registers IR and next-PC and derives the execute,
// writeback and memory control words from the captured instruction opcode.
module lc3_decode_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    lc3_decode_stage_if.slave dec
);

    if (WIDTH != 16) begin : g_width_check
        $error("lc3_decode_stage: only WIDTH = 16 is supported");
    end

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [3:0]       opcode_s;
    logic [1:0]       alu_ctrl_s;
    logic [1:0]       pcsel1_s;
    logic             pcsel2_s;
    logic             op2sel_s;
    logic [1:0]       w_ctrl_s;
    logic             mem_ctrl_s;

    logic [WIDTH-1:0] instr_d, instr_q;
    logic [WIDTH-1:0] npc_d,   npc_q;
    logic [5:0]       e_ctrl_d, e_ctrl_q;
    logic [1:0]       w_ctrl_d, w_ctrl_q;
    logic             mem_ctrl_d, mem_ctrl_q;

    assign opcode_s = dec.dout[15:12];

    // Opcode decode of the incoming instruction word (only loaded when enabled)
    always_comb begin
        alu_ctrl_s = 2'b00;
        pcsel1_s   = 2'b00;
        pcsel2_s   = 1'b0;
        op2sel_s   = 1'b0;
        w_ctrl_s   = 2'b00;
        mem_ctrl_s = 1'b0;
        case (opcode_s)
            OP_ADD: begin
                alu_ctrl_s = 2'b00;
                op2sel_s   = ~dec.dout[5];
            end
            OP_AND: begin
                alu_ctrl_s = 2'b01;
                op2sel_s   = ~dec.dout[5];
            end
            OP_NOT: begin
                alu_ctrl_s = 2'b10;
                op2sel_s   = 1'b1;
            end
            OP_BR, OP_ST: begin
                pcsel1_s = 2'b01;
                pcsel2_s = 1'b1;
            end
            OP_LD: begin
                pcsel1_s = 2'b01;
                pcsel2_s = 1'b1;
                w_ctrl_s = 2'b10;
            end
            OP_LDI: begin
                pcsel1_s   = 2'b01;
                pcsel2_s   = 1'b1;
                w_ctrl_s   = 2'b10;
                mem_ctrl_s = 1'b1;
            end
            OP_STI: begin
                pcsel1_s   = 2'b01;
                pcsel2_s   = 1'b1;
                mem_ctrl_s = 1'b1;
            end
            OP_LEA: begin
                pcsel1_s = 2'b01;
                pcsel2_s = 1'b1;
                w_ctrl_s = 2'b01;
            end
            OP_LDR: begin
                pcsel1_s = 2'b10;
                w_ctrl_s = 2'b10;
            end
            OP_STR: begin
                pcsel1_s = 2'b10;
            end
            OP_JMP: begin
                pcsel1_s = 2'b11;
            end
            // RTI, reserved and TRAP leave every control field cleared
            default: begin
                alu_ctrl_s = 2'b00;
                pcsel1_s   = 2'b00;
                pcsel2_s   = 1'b0;
                op2sel_s   = 1'b0;
                w_ctrl_s   = 2'b00;
                mem_ctrl_s = 1'b0;
            end
        endcase
    end

    // Next-state selection: capture on enable, otherwise hold so disabled inputs never leak through
    always_comb begin
        instr_d    = instr_q;
        npc_d      = npc_q;
        e_ctrl_d   = e_ctrl_q;
        w_ctrl_d   = w_ctrl_q;
        mem_ctrl_d = mem_ctrl_q;
        if (dec.enable_decode) begin
            instr_d    = dec.dout;
            npc_d      = dec.npc_in;
            e_ctrl_d   = {alu_ctrl_s, pcsel1_s, pcsel2_s, op2sel_s};
            w_ctrl_d   = w_ctrl_s;
            mem_ctrl_d = mem_ctrl_s;
        end else begin
            instr_d    = instr_q;
            npc_d      = npc_q;
            e_ctrl_d   = e_ctrl_q;
            w_ctrl_d   = w_ctrl_q;
            mem_ctrl_d = mem_ctrl_q;
        end
    end

    // Output registers with synchronous reset taking priority over enable
    always_ff @(posedge clock) begin
        if (reset) begin
            instr_q    <= {WIDTH{1'b0}};
            npc_q      <= {WIDTH{1'b0}};
            e_ctrl_q   <= 6'b000000;
            w_ctrl_q   <= 2'b00;
            mem_ctrl_q <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            npc_q      <= npc_d;
            e_ctrl_q   <= e_ctrl_d;
            w_ctrl_q   <= w_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
        end
    end

    assign dec.instr_dout    = instr_q;
    assign dec.npc_out       = npc_q;
    assign dec.E_control_i   = e_ctrl_q;
    assign dec.W_control_i   = w_ctrl_q;
    assign dec.Mem_control_i = mem_ctrl_q;

endmodule
